// File: rtl/cgra_axi_csr.sv
// AXI4-Lite control/status register block for the CGRA control unit.
// Independent AW/W holding registers, one outstanding write, registered read path.
module cgra_axi_csr #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] ID_VALUE   = 32'hC6A0_0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  start_o,
  output logic                  soft_reset_o,
  output logic [31:0]           max_cycles_o,
  input  logic                  busy_i,
  input  logic                  done_i,
  input  logic [31:0]           cycle_count_i,
  output logic                  irq_o
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [IW-1:0] IDX_CTRL   = IW'(0);
  localparam logic [IW-1:0] IDX_STATUS = IW'(1);
  localparam logic [IW-1:0] IDX_CYCLE  = IW'(2);
  localparam logic [IW-1:0] IDX_MAX    = IW'(11);
  localparam logic [IW-1:0] IDX_ID     = IW'(12);
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  logic          aw_held_q, aw_held_d;
  logic [IW-1:0] awidx_q, awidx_d;
  logic          w_held_q, w_held_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic          start_q, start_d;
  logic          soft_reset_q, soft_reset_d;
  logic          irq_en_q, irq_en_d;
  logic          done_q, done_d;
  logic [31:0]   max_cycles_q, max_cycles_d;
  logic          irq_q, irq_d;

  logic          aw_hs, w_hs, ar_hs, commit, done_clr;
  logic [IW-1:0] aridx;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  assign aridx            = s_axi_araddr[ADDR_WIDTH-1:2];

  // Ready outputs are held low while reset is asserted.
  assign s_axi_awready = rst_n & ~aw_held_q & ~bvalid_q;
  assign s_axi_wready  = rst_n & ~w_held_q & ~bvalid_q;
  assign s_axi_arready = rst_n & ~rvalid_q;

  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign start_o       = start_q;
  assign soft_reset_o  = soft_reset_q;
  assign max_cycles_o  = max_cycles_q;
  assign irq_o         = irq_q;

  always_comb begin
    aw_held_d    = aw_held_q;
    awidx_d      = awidx_q;
    w_held_d     = w_held_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    rvalid_d     = rvalid_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    start_d      = 1'b0;
    soft_reset_d = soft_reset_q;
    irq_en_d     = irq_en_q;
    max_cycles_d = max_cycles_q;
    done_clr     = 1'b0;

    aw_hs  = s_axi_awvalid & s_axi_awready;
    w_hs   = s_axi_wvalid & s_axi_wready;
    ar_hs  = s_axi_arvalid & s_axi_arready;
    commit = aw_held_q & w_held_q & ~bvalid_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awidx_d   = s_axi_awaddr[ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OKAY;
      case (awidx_q)
        IDX_CTRL: begin
          if (wstrb_q[0]) begin
            soft_reset_d = wdata_q[1];
            irq_en_d     = wdata_q[2];
            // START is dropped while the control unit is still busy.
            if (wdata_q[0] && !busy_i) begin
              start_d  = 1'b1;
              done_clr = 1'b1;
            end
          end
        end
        IDX_STATUS: begin
          if (wstrb_q[0] && wdata_q[1]) done_clr = 1'b1;
        end
        IDX_MAX: begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) max_cycles_d[8*b +: 8] = wdata_q[8*b +: 8];
          end
        end
        IDX_CYCLE, IDX_ID: ;
        default: bresp_d = RESP_SLVERR;
      endcase
    end else if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
    end

    // A done pulse beats any same-cycle clear.
    done_d = done_i ? 1'b1 : (done_clr ? 1'b0 : done_q);
    irq_d  = done_q & irq_en_q;

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      rdata_d  = 32'd0;
      case (aridx)
        IDX_CTRL:   rdata_d = {29'd0, irq_en_q, soft_reset_q, 1'b0};
        IDX_STATUS: rdata_d = {30'd0, done_q, busy_i};
        IDX_CYCLE:  rdata_d = cycle_count_i;
        IDX_MAX:    rdata_d = max_cycles_q;
        IDX_ID:     rdata_d = ID_VALUE;
        default:    rresp_d = RESP_SLVERR;
      endcase
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_q    <= 1'b0;
      awidx_q      <= '0;
      w_held_q     <= 1'b0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
      rresp_q      <= 2'b00;
      start_q      <= 1'b0;
      soft_reset_q <= 1'b0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      max_cycles_q <= 32'd0;
      irq_q        <= 1'b0;
    end else begin
      aw_held_q    <= aw_held_d;
      awidx_q      <= awidx_d;
      w_held_q     <= w_held_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      start_q      <= start_d;
      soft_reset_q <= soft_reset_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      max_cycles_q <= max_cycles_d;
      irq_q        <= irq_d;
    end
  end

endmodule

// File: tb/tb_cgra_axi_csr.sv
// Self-checking bench for cgra_axi_csr: directed scenarios plus randomized
// register traffic checked against a register-level model.
module tb_cgra_axi_csr;

  localparam logic [31:0] ID = 32'hC6A0_0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [7:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic        start_o;
  logic        soft_reset_o;
  logic [31:0] max_cycles_o;
  logic        busy_i = 1'b0;
  logic        done_i = 1'b0;
  logic [31:0] cycle_count_i = '0;
  logic        irq_o;

  cgra_axi_csr #(.ADDR_WIDTH(8), .ID_VALUE(ID)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .start_o(start_o), .soft_reset_o(soft_reset_o), .max_cycles_o(max_cycles_o),
    .busy_i(busy_i), .done_i(done_i), .cycle_count_i(cycle_count_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;

  always @(negedge clk) if (start_o) start_cnt++;

  // Register-level reference model
  logic        m_soft = 1'b0, m_irq_en = 1'b0, m_done = 1'b0;
  logic [31:0] m_max = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
    r = 2'b00;
    case (a[7:2])
      6'd0: if (s[0]) begin
        m_soft   = d[1];
        m_irq_en = d[2];
        if (d[0] && !busy_i) m_done = 1'b0;
      end
      6'd1: if (s[0] && d[1]) m_done = 1'b0;
      6'd2, 6'd12: ;
      6'd11: for (int b = 0; b < 4; b++) if (s[b]) m_max[8*b +: 8] = d[8*b +: 8];
      default: r = 2'b10;
    endcase
  endtask

  task automatic exp_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    r = 2'b00;
    d = 32'd0;
    case (a[7:2])
      6'd0:  d = {29'd0, m_irq_en, m_soft, 1'b0};
      6'd1:  d = {30'd0, m_done, busy_i};
      6'd2:  d = cycle_count_i;
      6'd11: d = m_max;
      6'd12: d = ID;
      default: r = 2'b10;
    endcase
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] r);
    int  n;
    logic aw_hs, w_hs;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    while ((s_axi_awvalid || s_axi_wvalid) && n < 20) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      tick();
      if (aw_hs) s_axi_awvalid = 1'b0;
      if (w_hs)  s_axi_wvalid  = 1'b0;
      n++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin tick(); n++; end
    check("wr_bvalid", 32'(s_axi_bvalid), 32'd1);
    r = s_axi_bresp;
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    $display("[TB] write addr=%02h data=%08h strb=%h bresp=%0d", a, d, s, r);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin tick(); n++; end
    tick();
    s_axi_arvalid = 1'b0;
    check("rd_rvalid", 32'(s_axi_rvalid), 32'd1);
    d = s_axi_rdata; r = s_axi_rresp;
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    $display("[TB] read  addr=%02h rdata=%08h rresp=%0d", a, d, r);
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    rd(a, d, r);
    exp_read(a, ed, er);
    check({tag, "_rdata"}, d, ed);
    check({tag, "_rresp"}, 32'(r), 32'(er));
  endtask

  task automatic wr_check(input string tag, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic [1:0] r, er;
    model_write(a, d, s, er);
    wr(a, d, s, r);
    check({tag, "_bresp"}, 32'(r), 32'(er));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [31:0] d;
    logic [3:0]  s;
    logic [7:0]  a;

    // Reset state
    #2;
    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_wready", 32'(s_axi_wready), 32'd0);
    check("rst_arready", 32'(s_axi_arready), 32'd0);
    check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    check("rst_outs", {start_o, soft_reset_o, irq_o}, 32'd0);
    check("rst_max", max_cycles_o, 32'd0);
    #20 rst_n = 1'b1;
    #1;

    // MAX_CYCLES write/read
    wr_check("max", 8'h2C, 32'h0000_0100, 4'hF);
    check("max_out", max_cycles_o, 32'h0000_0100);
    rd_check("max_rd", 8'h2C);

    // W three cycles ahead of AW, START with busy low
    busy_i = 1'b0;
    c0 = start_cnt;
    s_axi_wdata = 32'h1; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    check("s3_wready", 32'(s_axi_wready), 32'd1);
    tick();
    s_axi_wvalid = 1'b0;
    tick(); tick();
    s_axi_awaddr = 8'h00; s_axi_awvalid = 1'b1;
    check("s3_awready", 32'(s_axi_awready), 32'd1);
    tick();
    s_axi_awvalid = 1'b0;
    check("s3_bvalid_early", 32'(s_axi_bvalid), 32'd0);
    tick();
    check("s3_bvalid", 32'(s_axi_bvalid), 32'd1);
    check("s3_start_hi", 32'(start_o), 32'd1);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("s3_start_lo", 32'(start_o), 32'd0);
    tick(); tick();
    check("s3_start_cnt", 32'(start_cnt - c0), 32'd1);
    m_done = 1'b0;
    $display("[TB] early-W CTRL start write done");
    rd_check("s3_ctrl", 8'h00);

    // START while busy is dropped
    busy_i = 1'b1;
    c0 = start_cnt;
    wr_check("s4", 8'h00, 32'h1, 4'hF);
    tick();
    check("s4_no_start", 32'(start_cnt - c0), 32'd0);
    rd_check("s4_status", 8'h04);
    busy_i = 1'b0;

    // DONE / IRQ behaviour
    wr_check("irqen", 8'h00, 32'h4, 4'hF);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    m_done = 1'b1;
    check("irq_lag", 32'(irq_o), 32'd0);
    tick();
    check("irq_set", 32'(irq_o), 32'd1);
    rd_check("done_rd", 8'h04);
    s_axi_awaddr = 8'h04; s_axi_wdata = 32'h2; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check("coin_bvalid", 32'(s_axi_bvalid), 32'd1);
    check("coin_bresp", 32'(s_axi_bresp), 32'd0);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    $display("[TB] W1C coinciding with done_i");
    rd_check("coin_status", 8'h04);
    check("coin_irq", 32'(irq_o), 32'd1);
    wr_check("w1c_nostrb", 8'h04, 32'h2, 4'hE);
    rd_check("w1c_nostrb_rd", 8'h04);
    wr_check("w1c", 8'h04, 32'h2, 4'hF);
    check("w1c_irq", 32'(irq_o), 32'd0);
    rd_check("w1c_rd", 8'h04);

    // Unmapped, RO and ID accesses
    rd_check("bad_rd", 8'h10);
    wr_check("bad_wr", 8'h10, 32'hFFFF_FFFF, 4'hF);
    wr_check("ro_wr", 8'h30, 32'h1234_5678, 4'hF);
    rd_check("id_lowbits", 8'h33);
    s_axi_araddr = 8'h30; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("hold_rdata", s_axi_rdata, ID);
      check("hold_arready", 32'(s_axi_arready), 32'd0);
      tick();
    end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    check("hold_release", 32'(s_axi_arready), 32'd1);
    $display("[TB] read ID with rready held off");

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      busy_i = 1'($urandom_range(0, 1));
      cycle_count_i = $urandom;
      a = 8'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        wr_check("rnd_wr", a, d, s);
        check("rnd_max", max_cycles_o, m_max);
        check("rnd_soft", 32'(soft_reset_o), 32'(m_soft));
        check("rnd_irq", 32'(irq_o), 32'(m_done & m_irq_en));
      end else begin
        rd_check("rnd_rd", a);
      end
    end
    busy_i = 1'b0;

    // Async reset while a response is pending
    wr_check("soft", 8'h00, 32'h2, 4'hF);
    check("soft_out", 32'(soft_reset_o), 32'd1);
    s_axi_awaddr = 8'h2C; s_axi_wdata = 32'h5; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    tick();
    check("arst_pre_bvalid", 32'(s_axi_bvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("arst_soft", 32'(soft_reset_o), 32'd0);
    check("arst_max", max_cycles_o, 32'd0);
    check("arst_irq", 32'(irq_o), 32'd0);
    check("arst_awready", 32'(s_axi_awready), 32'd0);
    m_soft = 1'b0; m_irq_en = 1'b0; m_done = 1'b0; m_max = 32'd0;
    #20 rst_n = 1'b1;
    $display("[TB] async reset with pending response");
    tick();
    rd_check("post_max", 8'h2C);
    rd_check("post_ctrl", 8'h00);
    rd_check("post_status", 8'h04);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cgra_axi_csr.md
CGRA_AXI_CSR -- requirements
Module: cgra_axi_csr

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the AXI4-Lite byte-address width.
REQ-002 The block SHALL have parameter ID_VALUE, default 32'hC6A0_0001, meaning the read-only ID register value.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have these ports (name  direction  width  meaning):
  clk  in  1  clock
  rst_n  in  1  async active-low reset
  s_axi_awaddr  in  ADDR_WIDTH  write address
  s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
  s_axi_wdata  in  32  write data
  s_axi_wstrb  in  4  byte strobes
  s_axi_wvalid / s_axi_wready  in / out  1  W handshake
  s_axi_bresp  out  2  write response
  s_axi_bvalid / s_axi_bready  out / in  1  B handshake
  s_axi_araddr  in  ADDR_WIDTH  read address
  s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
  s_axi_rdata  out  32  read data
  s_axi_rresp  out  2  read response
  s_axi_rvalid / s_axi_rready  out / in  1  R handshake
  start_o  out  1  one-cycle start pulse to the control unit
  soft_reset_o  out  1  level soft reset to the control unit
  max_cycles_o  out  32  timeout limit; 0 = none
  busy_i  in  1  control unit busy
  done_i  in  1  control unit one-cycle done pulse
  cycle_count_i  in  32  control unit cycle counter
  irq_o  out  1  level interrupt

Function
REQ-005 The register map SHALL be as follows; decoding uses addr[ADDR_WIDTH-1:2], and addr[1:0] is ignored:
  0x00 CTRL: bit0 START (write-1 pulse, reads 0); bit1 SOFT_RESET (RW); bit2 IRQ_EN (RW).
  0x04 STATUS: bit0 BUSY (RO, = busy_i); bit1 DONE (sticky, W1C).
  0x08 CYCLE_COUNT: RO, = cycle_count_i.
  0x2C MAX_CYCLES: RW.
  0x30 ID: RO, = ID_VALUE.
REQ-006 Any other address SHALL return SLVERR (2'b10) with rdata 0 on reads, and SLVERR with no side effect on writes; mapped addresses return OKAY (2'b00).
REQ-007 Writes to RO registers SHALL be ignored and SHALL respond OKAY.
REQ-008 AW and W SHALL be accepted independently into single holding registers.
  - awready = !aw_held && !bvalid.
  - wready = !w_held && !bvalid.
REQ-009 The commit edge SHALL be the first edge at which both aw_held and w_held are 1 and bvalid = 0.
  - At that edge: register updates take effect, bvalid is set, and both holds are cleared.
  - AW and W handshaking at edge N therefore give bvalid high after edge N+1.
REQ-010 bvalid SHALL stay high until the bready handshake; at most one write SHALL be outstanding.
REQ-011 For RW fields, only bytes with wstrb=1 SHALL update.
  - START and SOFT_RESET and IRQ_EN require wstrb[0].
  - DONE W1C requires wstrb[0].
REQ-012 start_o SHALL pulse high for exactly one cycle, the cycle following a commit edge that writes CTRL with START=1 and wstrb[0]=1, provided busy_i=0 at the commit edge.
  - Otherwise START is dropped silently; the response is still OKAY.
REQ-013 A START write that takes effect SHALL also clear DONE at the commit edge.
REQ-014 DONE SHALL set on any edge where done_i=1.
  - When set and clear (W1C or START) coincide, set wins.
REQ-015 soft_reset_o and max_cycles_o SHALL be direct register outputs.
REQ-016 irq_o SHALL be registered, = DONE && IRQ_EN, updating one cycle after either changes.
REQ-017 The read path SHALL operate as follows:
  - arready = !rvalid.
  - On the AR handshake edge, rdata/rresp are captured and rvalid is set.
  - rdata/rresp hold stable until the rready handshake clears rvalid.
REQ-018 Read data SHALL be sampled at the AR handshake edge.
  - Read/write to the same register in the same cycle returns the pre-write value.
REQ-019 The read and write channels SHALL operate concurrently and independently.

Reset
REQ-020 On rst_n low (asynchronous), the following SHALL be 0:
  - all handshake outputs, bresp/rresp/rdata
  - start_o, soft_reset_o, irq_o
  - CTRL, DONE, MAX_CYCLES
  - aw_held/w_held
REQ-021 After rst_n deasserts, the block SHALL accept transactions at the first rising edge.
REQ-022 Reset asserted mid-transaction SHALL abandon the transaction with no register update and no response.

Verification
REQ-023 The testbench SHALL cover:
  - Write 0x2C=0x0000_0100, wstrb=4'hF; read 0x2C -> rdata=0x0000_0100, OKAY; max_cycles_o=0x100 after the commit edge.
  - W issued 3 cycles before AW to 0x00 data=0x1, busy_i=0 -> bvalid 1 cycle after the AW handshake+1; start_o high exactly 1 cycle; read CTRL -> 0x0.
  - Write CTRL START with busy_i=1 -> bresp OKAY, start_o stays 0.
  - IRQ_EN=1; pulse done_i -> STATUS bit1=1, irq_o=1 next cycle; W1C 0x04=0x2 coinciding with another done_i pulse -> DONE stays 1; W1C alone -> DONE=0, irq_o=0.
  - Read 0x10 -> rresp=2'b10, rdata=0; write 0x10 -> bresp=2'b10; read 0x30 -> ID_VALUE; hold rready=0 for 5 cycles -> rdata stable, arready=0.
  - Assert rst_n low while bvalid=1 and SOFT_RESET=1 -> bvalid, soft_reset_o, and all registers 0 immediately, without waiting for a clock edge.
